// File: rtl/hdu_pkg.sv
// Shared definitions for the load-use hazard stall controller.
// The optional branch-in-ID hazard detection is enabled by defining BRANCH_ID_HAZARD_EN.
package hdu_pkg;

  // Stall FSM encoding
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Register $zero is hard-wired and never produces a hazard
  localparam int REG_ZERO = 0;

  // The timer must hold up to LOAD_LAT+1 bubbles (branch vs ID/EX load case)
  function automatic int timer_width(input int load_lat);
    return $clog2(load_lat + 2);
  endfunction

endpackage

// File: rtl/hdu_stall_timer.sv
// Loadable down-counter that tracks remaining stall cycles.
// The count holds while dec is low (external freeze) and stops at zero.
module hdu_stall_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: load wins, otherwise decrement towards zero when enabled
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so all flops update together at the edge.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and stall controller for a 5-stage pipeline.
// Holds PC and IF/ID and injects NOP control into ID/EX for LOAD_LAT cycles per hazard.
// Defining BRANCH_ID_HAZARD_EN adds branch-resolved-in-ID hazard ports and detection.
module hazard_stall_ctrl
  import hdu_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  idexrt,
  input  logic [RA_W-1:0]  ifidrs,
  input  logic [RA_W-1:0]  ifidrt,
  input  logic             idexmemrd,
  input  logic             ext_stall,
`ifdef BRANCH_ID_HAZARD_EN
  input  logic             ifidbranch,
  input  logic             idexregwr,
  input  logic [RA_W-1:0]  idexwa,
  input  logic             exmemmemrd,
  input  logic [RA_W-1:0]  exmemwa,
`endif
  output logic             pcen,
  output logic             ifidregwr,
  output logic             ctrlsig,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMR_W = timer_width(LOAD_LAT);
  typedef logic [TMR_W-1:0] tmr_t;
  localparam logic [RA_W-1:0] ZERO_RA = RA_W'(REG_ZERO);

  state_e           state_d, state_q;
  tmr_t             req;
  logic             hit_raw, hit, ext, stall;
  logic             tmr_load, tmr_dec, tmr_zero;
  tmr_t             tmr_val, tmr_cnt;
  logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef BRANCH_ID_HAZARD_EN
  logic br_alu, br_ld_idex, br_ld_exmem;
  assign br_alu      = ifidbranch && idexregwr && (idexwa != ZERO_RA) &&
                       ((idexwa == ifidrs) || (idexwa == ifidrt));
  assign br_ld_idex  = ifidbranch && idexmemrd && (idexwa != ZERO_RA) &&
                       ((idexwa == ifidrs) || (idexwa == ifidrt));
  assign br_ld_exmem = ifidbranch && exmemmemrd && (exmemwa != ZERO_RA) &&
                       ((exmemwa == ifidrs) || (exmemwa == ifidrt));
`endif

  // Bubble requirement for the instruction in IF/ID; the largest case wins
  always_comb begin
    req = '0;
    if (idexmemrd && (idexrt != ZERO_RA) && ((idexrt == ifidrs) || (idexrt == ifidrt))) begin
      req = tmr_t'(LOAD_LAT);
    end
`ifdef BRANCH_ID_HAZARD_EN
    if (br_alu && (req < tmr_t'(1))) begin
      req = tmr_t'(1);
    end
    if (br_ld_exmem && (req < tmr_t'(LOAD_LAT))) begin
      req = tmr_t'(LOAD_LAT);
    end
    if (br_ld_idex) begin
      req = tmr_t'(LOAD_LAT + 1);
    end
`endif
  end

  // Unknown inputs resolve to "no hazard" / "no freeze" so outputs stay defined
  assign hit_raw = (req != '0);
  assign hit     = (hit_raw === 1'b1);
  assign ext     = (ext_stall === 1'b1);
  assign tmr_val = req - 1'b1;

  hdu_stall_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

  // Next-state logic: arm the timer on a multi-cycle hazard, count down while not frozen
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit && (req != tmr_t'(1))) begin
          state_d  = STALL;
          tmr_load = 1'b1;
        end
      end
      STALL: begin
        if (tmr_zero) begin
          state_d = IDLE;
        end else if (!ext) begin
          tmr_dec = 1'b1;
          if (tmr_cnt == tmr_t'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pipeline control: stall in the hazard cycle itself; an external freeze injects no bubble
  always_comb begin
    stall     = 1'b0;
    pcen      = 1'b1;
    ifidregwr = 1'b1;
    ctrlsig   = 1'b0;
    if (rst_n) begin
      stall     = ((state_q == IDLE) && hit) || (state_q == STALL) || ext;
      pcen      = !stall;
      ifidregwr = !stall;
      ctrlsig   = stall && !ext;
    end
  end

  assign busy = rst_n && (state_q == STALL);

  // Saturating count of cycles with the PC held
  always_comb begin
    cnt_d = cnt_q;
    if (!pcen && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Performance counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl.
// dut_a: LOAD_LAT=1, CNT_W=4 ; dut_b: LOAD_LAT=3, CNT_W=16.
// Define BRANCH_ID_HAZARD_EN to also exercise the branch hazard ports.
module tb_hazard_stall_ctrl;

  typedef struct {
    logic       rst_n;
    logic [4:0] idexrt;
    logic [4:0] ifidrs;
    logic [4:0] ifidrt;
    logic       idexmemrd;
    logic       ext_stall;
  } in_t;

  typedef struct {
    string name;
    logic  pcen;
    logic  ifidregwr;
    logic  ctrlsig;
    logic  busy;
    bit    chk_cnt;
    int    cnt;
  } exp_t;

  typedef struct {
    in_t  vi;
    exp_t ve;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic       a_rst_n, a_idexmemrd, a_ext_stall;
  logic [4:0] a_idexrt, a_ifidrs, a_ifidrt;
  logic       a_pcen, a_ifidregwr, a_ctrlsig, a_busy;
  logic [3:0] a_stall_cnt;
  // dut_b signals
  logic        b_rst_n, b_idexmemrd, b_ext_stall;
  logic [4:0]  b_idexrt, b_ifidrs, b_ifidrt;
  logic        b_pcen, b_ifidregwr, b_ctrlsig, b_busy;
  logic [15:0] b_stall_cnt;
`ifdef BRANCH_ID_HAZARD_EN
  logic       a_ifidbranch, a_idexregwr, a_exmemmemrd;
  logic [4:0] a_idexwa, a_exmemwa;
  logic       b_ifidbranch, b_idexregwr, b_exmemmemrd;
  logic [4:0] b_idexwa, b_exmemwa;
`endif

  hazard_stall_ctrl #(.RA_W(5), .LOAD_LAT(1), .CNT_W(4)) dut_a (
    .clk        (clk),
    .rst_n      (a_rst_n),
    .idexrt     (a_idexrt),
    .ifidrs     (a_ifidrs),
    .ifidrt     (a_ifidrt),
    .idexmemrd  (a_idexmemrd),
    .ext_stall  (a_ext_stall),
`ifdef BRANCH_ID_HAZARD_EN
    .ifidbranch (a_ifidbranch),
    .idexregwr  (a_idexregwr),
    .idexwa     (a_idexwa),
    .exmemmemrd (a_exmemmemrd),
    .exmemwa    (a_exmemwa),
`endif
    .pcen       (a_pcen),
    .ifidregwr  (a_ifidregwr),
    .ctrlsig    (a_ctrlsig),
    .busy       (a_busy),
    .stall_cnt  (a_stall_cnt)
  );

  hazard_stall_ctrl #(.RA_W(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (
    .clk        (clk),
    .rst_n      (b_rst_n),
    .idexrt     (b_idexrt),
    .ifidrs     (b_ifidrs),
    .ifidrt     (b_ifidrt),
    .idexmemrd  (b_idexmemrd),
    .ext_stall  (b_ext_stall),
`ifdef BRANCH_ID_HAZARD_EN
    .ifidbranch (b_ifidbranch),
    .idexregwr  (b_idexregwr),
    .idexwa     (b_idexwa),
    .exmemmemrd (b_exmemmemrd),
    .exmemwa    (b_exmemwa),
`endif
    .pcen       (b_pcen),
    .ifidregwr  (b_ifidregwr),
    .ctrlsig    (b_ctrlsig),
    .busy       (b_busy),
    .stall_cnt  (b_stall_cnt)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic rst, input logic [4:0] rt,
                              input logic [4:0] rs, input logic [4:0] rtt, input logic memrd,
                              input logic ext, input logic pcen, input logic ctrl,
                              input logic busy, input bit chk, input int cnt);
    vec_t v;
    v.vi.rst_n     = rst;
    v.vi.idexrt    = rt;
    v.vi.ifidrs    = rs;
    v.vi.ifidrt    = rtt;
    v.vi.idexmemrd = memrd;
    v.vi.ext_stall = ext;
    v.ve.name      = nm;
    v.ve.pcen      = pcen;
    v.ve.ifidregwr = pcen;
    v.ve.ctrlsig   = ctrl;
    v.ve.busy      = busy;
    v.ve.chk_cnt   = chk;
    v.ve.cnt       = cnt;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge
  task automatic run_vec(input bit sel_b, input vec_t v);
    exp_t e;
    logic [31:0] act_cnt;
    if (sel_b) begin
      b_rst_n = v.vi.rst_n; b_idexrt = v.vi.idexrt; b_ifidrs = v.vi.ifidrs;
      b_ifidrt = v.vi.ifidrt; b_idexmemrd = v.vi.idexmemrd; b_ext_stall = v.vi.ext_stall;
    end else begin
      a_rst_n = v.vi.rst_n; a_idexrt = v.vi.idexrt; a_ifidrs = v.vi.ifidrs;
      a_ifidrt = v.vi.ifidrt; a_idexmemrd = v.vi.idexmemrd; a_ext_stall = v.vi.ext_stall;
    end
    sb_q.push_back(v.ve);
    @(negedge clk);
    e = sb_q.pop_front();
    if (sel_b) begin
      check({e.name, ".pcen"},      32'(b_pcen),      32'(e.pcen));
      check({e.name, ".ifidregwr"}, 32'(b_ifidregwr), 32'(e.ifidregwr));
      check({e.name, ".ctrlsig"},   32'(b_ctrlsig),   32'(e.ctrlsig));
      check({e.name, ".busy"},      32'(b_busy),      32'(e.busy));
      act_cnt = 32'(b_stall_cnt);
    end else begin
      check({e.name, ".pcen"},      32'(a_pcen),      32'(e.pcen));
      check({e.name, ".ifidregwr"}, 32'(a_ifidregwr), 32'(e.ifidregwr));
      check({e.name, ".ctrlsig"},   32'(a_ctrlsig),   32'(e.ctrlsig));
      check({e.name, ".busy"},      32'(a_busy),      32'(e.busy));
      act_cnt = 32'(a_stall_cnt);
    end
    if (e.chk_cnt) begin
      check({e.name, ".stall_cnt"}, act_cnt, 32'(e.cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; a_idexrt = '0; a_ifidrs = '0; a_ifidrt = '0; a_idexmemrd = 1'b0; a_ext_stall = 1'b0;
    b_rst_n = 1'b0; b_idexrt = '0; b_ifidrs = '0; b_ifidrt = '0; b_idexmemrd = 1'b0; b_ext_stall = 1'b0;
`ifdef BRANCH_ID_HAZARD_EN
    a_ifidbranch = 1'b0; a_idexregwr = 1'b0; a_exmemmemrd = 1'b0; a_idexwa = '0; a_exmemwa = '0;
    b_ifidbranch = 1'b0; b_idexregwr = 1'b0; b_exmemmemrd = 1'b0; b_idexwa = '0; b_exmemwa = '0;
`endif

    // dut_b table (LOAD_LAT=3):         name   rst rt  rs  rt' mrd ext | pc ctl bsy chk cnt
    tbl.push_back(mk("b_rst_forced",  0,  9,  9,  0, 1, 1,   1, 0, 0, 0, 0));
    tbl.push_back(mk("b_rst_cnt",     0,  0,  0,  0, 0, 0,   1, 0, 0, 1, 0));
    tbl.push_back(mk("b_idle",        1,  0,  0,  0, 0, 0,   1, 0, 0, 1, 0));
    tbl.push_back(mk("b_zero_reg",    1,  0,  0,  0, 1, 0,   1, 0, 0, 1, 0));
    tbl.push_back(mk("b_not_load",    1,  9,  9,  0, 0, 0,   1, 0, 0, 1, 0));
    tbl.push_back(mk("b_ll3_c1",      1,  9,  9,  0, 1, 0,   0, 1, 0, 1, 0));
    tbl.push_back(mk("b_ll3_c2",      1,  0,  9,  0, 0, 0,   0, 1, 1, 1, 1));
    tbl.push_back(mk("b_ll3_c3",      1,  0,  9,  0, 0, 0,   0, 1, 1, 1, 2));
    tbl.push_back(mk("b_ll3_done",    1,  0,  9,  0, 0, 0,   1, 0, 0, 1, 3));
    tbl.push_back(mk("b_ext_c1_rt",   1,  9,  3,  9, 1, 0,   0, 1, 0, 1, 3));
    tbl.push_back(mk("b_ext_c2",      1,  0,  3,  9, 0, 1,   0, 0, 1, 1, 4));
    tbl.push_back(mk("b_ext_c3",      1,  0,  3,  9, 0, 1,   0, 0, 1, 1, 5));
    tbl.push_back(mk("b_ext_c4",      1,  0,  3,  9, 0, 0,   0, 1, 1, 1, 6));
    tbl.push_back(mk("b_ext_c5",      1,  0,  3,  9, 0, 0,   0, 1, 1, 1, 7));
    tbl.push_back(mk("b_ext_done",    1,  0,  3,  9, 0, 0,   1, 0, 0, 1, 8));
    tbl.push_back(mk("b_pure_freeze", 1,  0,  0,  0, 0, 1,   0, 0, 0, 1, 8));
    tbl.push_back(mk("b_freeze_end",  1,  0,  0,  0, 0, 0,   1, 0, 0, 1, 9));
    tbl.push_back(mk("b_hit_ext_c1",  1,  9,  9,  0, 1, 1,   0, 0, 0, 1, 9));
    tbl.push_back(mk("b_hit_ext_c2",  1,  9,  9,  0, 1, 0,   0, 1, 1, 1, 10));
    tbl.push_back(mk("b_hit_ext_c3",  1,  9,  9,  0, 1, 0,   0, 1, 1, 1, 11));
    tbl.push_back(mk("b_hit_ext_end", 1,  0,  0,  0, 0, 0,   1, 0, 0, 1, 12));
    tbl.push_back(mk("b_abort_c1",    1,  9,  9,  0, 1, 0,   0, 1, 0, 1, 12));
    tbl.push_back(mk("b_abort_rst",   0,  0,  9,  0, 0, 0,   1, 0, 0, 1, 13));
    tbl.push_back(mk("b_abort_after", 1,  0,  9,  0, 0, 0,   1, 0, 0, 1, 0));
    tbl.push_back(mk("b_reg_differs", 1,  9, 10, 11, 1, 0,   1, 0, 0, 1, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) run_vec(1'b1, tbl[i]);

    // dut_a (LOAD_LAT=1, CNT_W=4): single-bubble hazard and counter saturation
    run_vec(1'b0, mk("a_rst_forced",  0, 9, 9, 0, 1, 1,  1, 0, 0, 1, 0));
    run_vec(1'b0, mk("a_idle",        1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0));
    run_vec(1'b0, mk("a_ll1_hit",     1, 9, 9, 0, 1, 0,  0, 1, 0, 1, 0));
    run_vec(1'b0, mk("a_ll1_after",   1, 0, 9, 0, 0, 0,  1, 0, 0, 1, 1));
    run_vec(1'b0, mk("a_zero_reg",    1, 0, 5, 0, 1, 0,  1, 0, 0, 1, 1));
    run_vec(1'b0, mk("a_rehit_c1",    1, 7, 0, 7, 1, 0,  0, 1, 0, 1, 1));
    run_vec(1'b0, mk("a_rehit_c2",    1, 7, 0, 7, 1, 0,  0, 1, 0, 1, 2));
    run_vec(1'b0, mk("a_rehit_end",   1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 3));
    for (int i = 0; i < 20; i++) begin
      run_vec(1'b0, mk($sformatf("a_sat_%0d", i), 1, 0, 0, 0, 0, 1, 0, 0, 0, 1,
                       (3 + i > 15) ? 15 : 3 + i));
    end
    run_vec(1'b0, mk("a_sat_hold",    1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 15));

`ifdef BRANCH_ID_HAZARD_EN
    // Branch vs ID/EX ALU write: one bubble
    a_ifidbranch = 1'b1; a_idexregwr = 1'b1; a_idexwa = 5'd8;
    run_vec(1'b0, mk("a_br_alu",      1, 0, 8, 0, 0, 0,  0, 1, 0, 1, 15));
    a_ifidbranch = 1'b0; a_idexregwr = 1'b0; a_idexwa = '0;
    run_vec(1'b0, mk("a_br_alu_end",  1, 0, 8, 0, 0, 0,  1, 0, 0, 1, 15));
    // Branch vs ID/EX load with LOAD_LAT=3: four bubbles
    b_ifidbranch = 1'b1; b_idexregwr = 1'b1; b_idexwa = 5'd8;
    run_vec(1'b1, mk("b_br_ld_c1",    1, 0, 8, 0, 1, 0,  0, 1, 0, 1, 0));
    b_ifidbranch = 1'b0; b_idexregwr = 1'b0; b_idexwa = '0;
    run_vec(1'b1, mk("b_br_ld_c2",    1, 0, 8, 0, 0, 0,  0, 1, 1, 1, 1));
    run_vec(1'b1, mk("b_br_ld_c3",    1, 0, 8, 0, 0, 0,  0, 1, 1, 1, 2));
    run_vec(1'b1, mk("b_br_ld_c4",    1, 0, 8, 0, 0, 0,  0, 1, 1, 1, 3));
    run_vec(1'b1, mk("b_br_ld_end",   1, 0, 8, 0, 0, 0,  1, 0, 0, 1, 4));
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
